// File: rtl/read_ctrl_exp_1x1.sv
// read_ctrl_exp_1x1: read-side address sequencer for the expand-1x1 kernel RAM.
// Replays the stored kernel words one depth slice (layer) at a time, on request
// from the datapath, with back-pressure and end-of-fire signalling.
//
// Handshake: a layer is granted when layer_req_i is high in a WAIT_REQ cycle.
// A word is issued in every READ cycle with stall_i low (ker_rd_en_o high).
// The RAM returns it one cycle later, when ker_valid_o rises. A stall drops
// the read for that cycle only. No word is lost and no word is repeated.
module read_ctrl_exp_1x1 #(
    parameter int ADDR_W = 12,
    parameter int LAYR_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              exp_1x1_en_i,
    input  logic [ADDR_W-1:0] tot_exp1_ker_addr_limit_i,
    input  logic [LAYR_W-1:0] one_exp1_ker_addr_limit_i,
    input  logic              layer_req_i,
    input  logic              stall_i,
    output logic              exp_1x1_en_o,
    output logic              busy_o,
    output logic              ker_rd_en_o,
    output logic [ADDR_W-1:0] ker_rd_addr_o,
    output logic              ker_valid_o,
    output logic              ker_layer_last_o,
    output logic              fire_done_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REQ = 2'd1,
        READ     = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_lim;
    logic [LAYR_W-1:0]   layr_lim;
    logic [LAYR_W-1:0]   layer_cnt;
    logic                at_addr_lim;
    logic                at_layr_lim;

    // A read is issued in every unstalled READ cycle; stall acts in the same cycle.
    assign ker_rd_en_o = (state == READ) & ~stall_i;
    assign at_addr_lim = (ker_rd_addr_o == addr_lim);
    assign at_layr_lim = (layer_cnt == layr_lim);

    // Sequencer FSM with its address/layer counters and registered read-side flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            exp_1x1_en_o     <= 1'b0;
            busy_o           <= 1'b0;
            addr_lim         <= '0;
            layr_lim         <= '0;
            layer_cnt        <= '0;
            ker_rd_addr_o    <= '0;
            ker_valid_o      <= 1'b0;
            ker_layer_last_o <= 1'b0;
            fire_done_o      <= 1'b0;
        end else begin
            ker_valid_o      <= ker_rd_en_o;
            ker_layer_last_o <= ker_rd_en_o & (at_layr_lim | at_addr_lim);
            fire_done_o      <= ker_rd_en_o & at_addr_lim;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        exp_1x1_en_o  <= exp_1x1_en_i;
                        addr_lim      <= tot_exp1_ker_addr_limit_i;
                        // A layer size of 0 wraps to 127, so it means 128 words.
                        layr_lim      <= one_exp1_ker_addr_limit_i - 1'b1;
                        ker_rd_addr_o <= '0;
                        layer_cnt     <= '0;
                        if (exp_1x1_en_i) begin
                            state  <= WAIT_REQ;
                            busy_o <= 1'b1;
                        end else begin
                            // The path is disabled, so the fire finishes at once without reads.
                            fire_done_o <= 1'b1;
                        end
                    end
                end
                WAIT_REQ: begin
                    if (layer_req_i) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (!stall_i) begin
                        ker_rd_addr_o <= ker_rd_addr_o + 1'b1;
                        layer_cnt     <= layer_cnt + 1'b1;
                        // The fire end wins over the layer end. This covers a short final layer.
                        if (at_addr_lim) begin
                            state  <= FLUSH;
                            busy_o <= 1'b0;
                        end else if (at_layr_lim) begin
                            layer_cnt <= '0;
                            state     <= WAIT_REQ;
                        end
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_read_ctrl_exp_1x1.sv
// tb_read_ctrl_exp_1x1: randomized bench with a word-list reference model.
module tb_read_ctrl_exp_1x1;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        exp_1x1_en_i = 1'b0;
  logic [11:0] tot_exp1_ker_addr_limit_i = '0;
  logic [6:0]  one_exp1_ker_addr_limit_i = '0;
  logic        layer_req_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        exp_1x1_en_o;
  logic        busy_o;
  logic        ker_rd_en_o;
  logic [11:0] ker_rd_addr_o;
  logic        ker_valid_o;
  logic        ker_layer_last_o;
  logic        fire_done_o;

  read_ctrl_exp_1x1 dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .start_i                   (start_i),
    .exp_1x1_en_i              (exp_1x1_en_i),
    .tot_exp1_ker_addr_limit_i (tot_exp1_ker_addr_limit_i),
    .one_exp1_ker_addr_limit_i (one_exp1_ker_addr_limit_i),
    .layer_req_i               (layer_req_i),
    .stall_i                   (stall_i),
    .exp_1x1_en_o              (exp_1x1_en_o),
    .busy_o                    (busy_o),
    .ker_rd_en_o               (ker_rd_en_o),
    .ker_rd_addr_o             (ker_rd_addr_o),
    .ker_valid_o               (ker_valid_o),
    .ker_layer_last_o          (ker_layer_last_o),
    .fire_done_o               (fire_done_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Each expected entry is {done, last, addr[11:0]}.
  logic [13:0] exp_q[$];
  logic        chk_en   = 1'b0;
  logic        m_active = 1'b0;
  logic        m_wait   = 1'b0;
  int          m_left   = 0;
  int          m_len    = 1;
  logic        m_en     = 1'b0;
  logic        pend_v   = 1'b0;
  logic [13:0] pend_e   = '0;
  logic        pend_dis = 1'b0;
  logic        chk_zero = 1'b0;

  // Observed statistics, used for the hand-computed literal checks.
  int n_valid = 0;
  int n_last  = 0;
  int n_done  = 0;
  int done_addr = -1;
  int last_addrs[$];
  int prev_issue = 0;

  // Build the word list of one fire from the layer arithmetic.
  task automatic load_fire(input int tot, input int one);
    int len;
    len = (one == 0) ? 128 : one;
    m_len = len;
    exp_q.delete();
    for (int a = 0; a <= tot; a++) begin
      logic last;
      last = (((a + 1) % len) == 0) || (a == tot);
      exp_q.push_back({(a == tot), last, a[11:0]});
    end
  endtask

  // compare process: checks every cycle, then advances the model across the next edge
  always @(negedge clk_i) begin
    if (chk_en) begin
      logic exp_rd, flush_now, act_top, set_wait;
      logic [13:0] e;
      act_top   = m_active;
      flush_now = pend_v & pend_e[13];
      set_wait  = 1'b0;
      chk("busy", busy_o, m_active);
      chk("exp_en", exp_1x1_en_o, m_en);
      chk("valid", ker_valid_o, pend_v);
      chk("layer_last", ker_layer_last_o, pend_v & pend_e[12]);
      chk("fire_done", fire_done_o, (pend_v & pend_e[13]) | pend_dis);
      if (chk_zero) chk("addr_after_rst", ker_rd_addr_o, 0);
      exp_rd = (m_left > 0) && !stall_i;
      chk("rd_en", ker_rd_en_o, exp_rd);

      // statistics from DUT outputs
      if (ker_valid_o) n_valid++;
      if (ker_layer_last_o) begin n_last++; last_addrs.push_back(prev_issue); end
      if (fire_done_o) begin n_done++; done_addr = pend_dis ? -1 : prev_issue; end
      if (ker_rd_en_o) prev_issue = ker_rd_addr_o;

      pend_v = 1'b0;
      pend_dis = 1'b0;
      chk_zero = 1'b0;
      if (exp_rd) begin
        if (exp_q.size() == 0) begin
          chk("queue_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_addr", ker_rd_addr_o, e[11:0]);
          pend_v = 1'b1;
          pend_e = e;
          m_left--;
          if (e[13]) begin
            m_left = 0;
            m_active = 1'b0;
          end else if (m_left == 0) begin
            set_wait = 1'b1;
          end
        end
      end
      if (m_wait && layer_req_i) begin
        m_left = m_len;
        m_wait = 1'b0;
      end
      if (set_wait) m_wait = 1'b1;
      if (start_i && !act_top && !flush_now) begin
        m_en = exp_1x1_en_i;
        if (exp_1x1_en_i) begin
          load_fire(int'(tot_exp1_ker_addr_limit_i), int'(one_exp1_ker_addr_limit_i));
          m_active = 1'b1;
          m_wait = 1'b1;
          m_left = 0;
        end else begin
          pend_dis = 1'b1;
        end
      end
      if (rst_i) begin
        exp_q.delete();
        m_active = 1'b0;
        m_wait = 1'b0;
        m_left = 0;
        m_en = 1'b0;
        pend_v = 1'b0;
        pend_dis = 1'b0;
        chk_zero = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_stats();
    n_valid = 0;
    n_last = 0;
    done_addr = -1;
    last_addrs.delete();
  endtask

  // Run one enabled fire. req_mode 1 ties layer_req_i high; 0 randomizes it.
  // stall_at >= 0 inserts a 3-cycle stall when that address is up next.
  // second_at > 0 pulses a conflicting start_i that many cycles into the fire.
  task automatic run_fire(input int tot, input int one, input int req_mode,
                          input int stall_pct, input int stall_at, input int second_at);
    int d0, cyc, stall_left;
    logic stalled_once;
    clear_stats();
    d0 = n_done;
    stall_left = 0;
    stalled_once = 1'b0;
    exp_1x1_en_i = 1'b1;
    tot_exp1_ker_addr_limit_i = tot[11:0];
    one_exp1_ker_addr_limit_i = one[6:0];
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    cyc = 0;
    while (n_done == d0 && cyc < 5000) begin
      layer_req_i = (req_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      start_i = (second_at > 0 && cyc == second_at);
      if (start_i) begin
        tot_exp1_ker_addr_limit_i = 12'd3;
        one_exp1_ker_addr_limit_i = 7'd1;
      end
      if (stall_at >= 0 && !stalled_once && ker_rd_addr_o == stall_at[11:0] && cyc > 0) begin
        stalled_once = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        stall_i = 1'b1;
        stall_left--;
      end else begin
        stall_i = ($urandom_range(0, 99) < stall_pct);
      end
      step();
      cyc++;
    end
    start_i = 1'b0;
    stall_i = 1'b0;
    layer_req_i = 1'b0;
    if (n_done == d0) chk("fire_timeout", 1, 0);
    step();
    step();
  endtask

  initial begin
    int d0, cyc;
    // Reset phase.
    step();
    chk_en = 1'b1;
    step();
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", ker_valid_o, 0);
    chk("rst_addr", ker_rd_addr_o, 0);
    rst_i = 1'b0;
    step();

    // 64 kernels, depth 16.
    run_fire(255, 16, 1, 0, -1, 0);
    chk("t1_valids", n_valid, 256);
    chk("t1_lasts", n_last, 16);
    chk("t1_first_last", last_addrs[0], 15);
    chk("t1_final_last", last_addrs[15], 255);
    chk("t1_done_addr", done_addr, 255);

    // The final layer is short.
    run_fire(9, 4, 1, 0, -1, 0);
    chk("t2_lasts", n_last, 3);
    chk("t2_last0", last_addrs[0], 3);
    chk("t2_last1", last_addrs[1], 7);
    chk("t2_last2", last_addrs[2], 9);
    chk("t2_done_addr", done_addr, 9);

    // A 3-cycle stall in the middle of a layer.
    run_fire(23, 8, 1, 0, 3, 0);
    chk("t3_valids", n_valid, 24);
    chk("t3_lasts", n_last, 3);

    // The path is disabled, so only a fire_done pulse occurs.
    clear_stats();
    d0 = n_done;
    exp_1x1_en_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    chk("t4_done_cnt", n_done, d0 + 1);
    chk("t4_valids", n_valid, 0);

    // A second start during READ is ignored.
    run_fire(15, 4, 1, 0, -1, 5);
    chk("t5_valids", n_valid, 16);
    chk("t5_done_addr", done_addr, 15);

    // Reset mid-layer at address 5, then restart.
    exp_1x1_en_i = 1'b1;
    tot_exp1_ker_addr_limit_i = 12'd31;
    one_exp1_ker_addr_limit_i = 7'd8;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    layer_req_i = 1'b1;
    cyc = 0;
    while (!(ker_rd_en_o && ker_rd_addr_o == 12'd5) && cyc < 100) begin
      step();
      cyc++;
    end
    if (cyc >= 100) chk("t6_wait_addr5", 1, 0);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    layer_req_i = 1'b0;
    chk("t6_busy", busy_o, 0);
    chk("t6_valid", ker_valid_o, 0);
    chk("t6_rd_en", ker_rd_en_o, 0);
    chk("t6_addr", ker_rd_addr_o, 0);
    step();
    run_fire(7, 4, 1, 0, -1, 0);
    chk("t6_restart_valids", n_valid, 8);

    // Random fires with random requests and stalls.
    for (int i = 0; i < 12; i++) begin
      int tot, one;
      tot = $urandom_range(0, 200);
      one = (i == 3) ? 0 : $urandom_range(1, 20);
      run_fire(tot, one, 0, 30, -1, 0);
      chk("rand_valids", n_valid, tot + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/read_ctrl_exp_1x1.md
# read_ctrl_exp_1x1

Read-side address sequencer for the expand-1x1 kernel weight RAM inside the fire layer. It latches the same layer configuration that the write side uses: total words per fire and words per input-depth slice. It then replays the stored kernel words to the 1x1 MAC array one depth slice ("layer") at a time, on request from the datapath. It drives the RAM read port (1-cycle read latency), flags data-valid, last-of-layer and end-of-fire, and supports back-pressure.

## Interface
Parameters:
- ADDR_W, 12, kernel RAM address width (matches total-limit width)
- LAYR_W, 7, words-per-layer counter width

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_i  in  1  reset; synchronous, active-high
- start_i  in  1  one-cycle pulse; latch config, begin fire; ignored while busy_o=1
- exp_1x1_en_i  in  1  expand-1x1 path enabled for this fire
- tot_exp1_ker_addr_limit_i  in  12  last RAM address of fire = (kernels*depth)/4 - 1
- one_exp1_ker_addr_limit_i  in  7  words per layer = kernels/4
- layer_req_i  in  1  datapath ready to consume next layer's kernel words
- stall_i  in  1  downstream back-pressure; freezes reading
- exp_1x1_en_o  out  1  latched enable
- busy_o  out  1  high from start acceptance until fire_done_o
- ker_rd_en_o  out  1  RAM read enable
- ker_rd_addr_o  out  12  RAM read address
- ker_valid_o  out  1  RAM data valid (ker_rd_en_o delayed 1 cycle)
- ker_layer_last_o  out  1  with ker_valid_o: last word of current layer
- fire_done_o  out  1  one-cycle pulse: fire complete

## Operation
- Reset: all outputs 0, address/layer counters 0, state IDLE.
- Config latch on accepted start_i: exp_1x1_en_o<=exp_1x1_en_i; addr_lim<=tot limit; layr_lim<=one limit - 1 (7-bit wrap: 0 gives 127, i.e. 128 words); rd addr<=0; layer cnt<=0.
- FSM:
  - IDLE -> WAIT_REQ on start_i with exp_1x1_en_i=1.
  - IDLE with start_i and exp_1x1_en_i=0: stay IDLE; fire_done_o pulses the next cycle; no reads.
  - WAIT_REQ -> READ when layer_req_i=1.
  - READ, each cycle with stall_i=0: ker_rd_en_o=1 (combinational: state==READ & ~stall_i), issue addr, then addr+1 and layer cnt+1.
  - READ, issued word has addr==addr_lim: go to FLUSH (fire end; also handles tot not a multiple of the layer size).
  - READ, else layer cnt==layr_lim: cnt<=0, go to WAIT_REQ.
  - FLUSH, 1 cycle: final valid emitted, then IDLE.
- ker_rd_addr_o is registered and holds its value while stalled or waiting. ker_rd_en_o=0 outside READ.
- ker_valid_o <= ker_rd_en_o. ker_layer_last_o <= (rd_en & (cnt==layr_lim | addr==addr_lim)).
- fire_done_o is asserted together with the valid of addr_lim and is a 1-cycle pulse. busy_o drops in the same cycle.
- start_i while busy: ignored. layer_req_i outside WAIT_REQ: ignored (not queued).
- rst_i mid-fire: next edge forces IDLE and clears outputs; an in-flight valid is dropped.

## Timing
- start_i at edge N -> WAIT_REQ and busy_o=1 from N+1.
- layer_req_i sampled high at edge M in WAIT_REQ -> first ker_rd_en_o in cycle M+1 -> ker_valid_o in cycle M+2.
- Unstalled layer of L words: L consecutive rd_en cycles, then valids 1 cycle later.
- If layer_req_i is held high, layers follow each other with exactly 1 bubble cycle (the WAIT_REQ cycle).
- stall_i is combinational into ker_rd_en_o: a stalled cycle issues no read, and the valid one cycle later is 0.
- Latency from last read issue to fire_done_o is 1 cycle.

## Test plan
- 64 kernels, depth 16 (tot=255, one=16), layer_req_i tied high -> addrs 0..255 in order; 16 ker_layer_last_o pulses at addrs 15,31,..,255; fire_done_o once, with the addr-255 valid; 256 valids total.
- tot=9, one=4, layer_req_i tied high -> layers of 4,4,2 words; last pulses at addrs 3,7,9; fire_done_o with addr 9.
- stall_i high for 3 cycles mid-layer (one=8) -> address frozen, no rd_en, no valids during the stall; sequence resumes without loss or duplication.
- start_i with exp_1x1_en_i=0 -> no rd_en, busy_o stays 0, fire_done_o pulse 1 cycle after start.
- Second start_i during READ with different limits -> ignored; the first fire completes with the original limits.
- rst_i asserted mid-layer at addr 5 -> next cycle all outputs 0, state IDLE; a new start_i then restarts reading at addr 0.
